id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
ID/EX pipeline register and operand-select front end for the execute-stage ALU. It captures decoded fields from ID and applies EX/MEM and MEM/WB forwarding. It drives alu_op, operand1 and operand2 straight into the ALU. It also detects load-use hazards, inserts bubbles, and honours downstream stall and branch flush.

Parameters:
XLEN, 32, datapath width
RA_W, 5, register-address width
OP_W, 4, ALU opcode width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
stall  in  1  downstream hold; freezes this stage
flush  in  1  branch/trap kill; loads a bubble
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  instruction PC
id_rs1_addr, id_rs2_addr, id_rd_addr  in  RA_W  register indices
id_rs1_data, id_rs2_data  in  XLEN  register-file read data
id_uses_rs1, id_uses_rs2  in  1  instruction reads that source
id_imm  in  XLEN  sign-extended immediate
id_alu_op  in  OP_W  ALU opcode, passed through opaquely
id_op1_sel, id_op2_sel  in  2  operand-select codes
id_reg_write, id_mem_read, id_mem_write  in  1  control flags
exmem_reg_write  in  1  EX/MEM writes rd
exmem_rd_addr  in  RA_W  EX/MEM destination index
exmem_result  in  XLEN  EX/MEM result
memwb_reg_write  in  1  MEM/WB writes rd
memwb_rd_addr  in  RA_W  MEM/WB destination index
memwb_result  in  XLEN  MEM/WB result
load_use_hazard  out  1  freezes PC and IF/ID this cycle
ex_valid  out  1  EX holds a real instruction
ex_pc  out  XLEN  registered PC
ex_alu_op  out  OP_W  to ALU alu_op
operand1, operand2  out  XLEN  to ALU operand1/operand2
ex_store_data  out  XLEN  forwarded rs2, for stores
ex_rd_addr  out  RA_W  registered destination index
ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered control, gated by ex_valid

Behaviour:
- Reset (async, immediate): ex_valid=0; all registered fields 0. Consequently all outputs are 0, including load_use_hazard.
- Per-edge priority is rst > flush > stall > load_use_hazard > normal.
  - flush: load a bubble (valid=0, all control 0). Flush wins over a simultaneous stall.
  - stall (no flush): hold every field except rs1_data/rs2_data. These are rewritten with the currently forwarded values, so producers that retire during the hold are not lost.
  - load_use_hazard (no stall, no flush): load a bubble; the ID instruction is re-presented next cycle.
  - normal: capture all id_* fields; valid=id_valid.
- Hazard rule, combinational:
  - load_use_hazard = ex_valid & ex_mem_read & ex_rd_addr!=0 & id_valid & ((id_uses_rs1 & id_rs1_addr==ex_rd_addr) | (id_uses_rs2 & id_rs2_addr==ex_rd_addr)).
  - The bubble therefore lasts exactly 1 cycle.
- Forwarding, combinational on registered state, applied per source:
  - EX/MEM when exmem_reg_write and rd==rs and rs!=0.
  - Otherwise MEM/WB under the same condition.
  - Otherwise the registered register-file data.
  - EX/MEM wins when both sources match. x0 is never forwarded.
- Operand select, combinational:
  - op1_sel: 0=fwd rs1, 1=pc, 2=zero, 3=zero.
  - op2_sel: 0=fwd rs2, 1=imm, 2=constant 4, 3=zero.
  - ex_store_data is always the forwarded rs2.
- Latency: an ID instruction appears at the ALU inputs one cycle after its capture edge; the forwarding path adds no latency.
- ex_reg_write, ex_mem_read and ex_mem_write are forced 0 whenever ex_valid=0.
- Reset asserted mid-stall clears everything; on release the stage holds a bubble.

Decomposition:
- Package pipe_pkg holds OP1_RS1/OP1_PC/OP1_ZERO, OP2_RS2/OP2_IMM/OP2_FOUR/OP2_ZERO, and the id_ex_t struct of registered fields.
- ALU opcode encodings stay in the existing shared ALU definitions header.
- One sub-module: fwd_mux (rs addr, rs data, both producer ports → forwarded value), instantiated twice.

Test Plan:
1. ADD x3,x1,x2 with id_rs1_data=5, id_rs2_data=7, no forwarding → one cycle later operand1=5, operand2=7, ex_reg_write=1.
2. EX holds rs1=x4 and rs2=x4, with exmem rd=x4/0x10 and memwb rd=x4/0x20 both writing → operand1=0x10, operand2=0x10; the same case with rd=x0 → register-file data.
3. EX holds LW x5 (ex_mem_read=1) and ID presents ADD using rs2=x5 → load_use_hazard=1 for 1 cycle; next cycle ex_valid=0; the cycle after, the ADD is captured.
4. EX holds rs1=x6 forwarded from EX/MEM=0xAB, stall=1 for 2 cycles while the producer moves to MEM/WB and then out → operand1 stays 0xAB throughout.
5. flush=1 and stall=1 on the same edge → ex_valid=0, ex_mem_write=0 next cycle.
6. rst pulsed asynchronously mid-cycle while ex_valid=1 → all outputs 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the ID/EX pipeline stage:
//   - default datapath widths used to size the registered ID/EX record
//   - operand-select encodings for operand1 / operand2
//   - id_ex_t, the record of fields held in the ID/EX pipeline register
// ALU opcodes are not defined here; the stage carries alu_op opaquely.
// -----------------------------------------------------------------------------
package pipe_pkg;

   localparam int PIPE_XLEN = 32;
   localparam int PIPE_RA_W = 5;
   localparam int PIPE_OP_W = 4;

   // operand1 select codes (code 3 also selects zero)
   localparam logic [1:0] OP1_RS1  = 2'd0;
   localparam logic [1:0] OP1_PC   = 2'd1;
   localparam logic [1:0] OP1_ZERO = 2'd2;

   // operand2 select codes
   localparam logic [1:0] OP2_RS2  = 2'd0;
   localparam logic [1:0] OP2_IMM  = 2'd1;
   localparam logic [1:0] OP2_FOUR = 2'd2;
   localparam logic [1:0] OP2_ZERO = 2'd3;

   // Everything the stage registers on a capture edge. An all-zero record is
   // a bubble: invalid, no control side effects, x0 sources.
   typedef struct packed {
      logic                 valid;
      logic [PIPE_XLEN-1:0] pc;
      logic [PIPE_RA_W-1:0] rs1_addr;
      logic [PIPE_RA_W-1:0] rs2_addr;
      logic [PIPE_RA_W-1:0] rd_addr;
      logic [PIPE_XLEN-1:0] rs1_data;
      logic [PIPE_XLEN-1:0] rs2_data;
      logic [PIPE_XLEN-1:0] imm;
      logic [PIPE_OP_W-1:0] alu_op;
      logic [1:0]           op1_sel;
      logic [1:0]           op2_sel;
      logic                 reg_write;
      logic                 mem_read;
      logic                 mem_write;
   } id_ex_t;

endpackage

// File: rtl/fwd_mux.sv
// -----------------------------------------------------------------------------
// fwd_mux
// Resolves one source operand against the two in-flight producers.
// EX/MEM has priority over MEM/WB because it holds the younger result;
// x0 is never forwarded.
// Ports:
//   rs_addr, rs_data                      source index and register-file data
//   exmem_reg_write/rd_addr/result        EX/MEM producer
//   memwb_reg_write/rd_addr/result        MEM/WB producer
//   fwd_data                              resolved operand value
// -----------------------------------------------------------------------------
module fwd_mux
   import pipe_pkg::*;
#(
   parameter int XLEN = PIPE_XLEN,
   parameter int RA_W = PIPE_RA_W
) (
   input  logic [RA_W-1:0] rs_addr,
   input  logic [XLEN-1:0] rs_data,
   input  logic            exmem_reg_write,
   input  logic [RA_W-1:0] exmem_rd_addr,
   input  logic [XLEN-1:0] exmem_result,
   input  logic            memwb_reg_write,
   input  logic [RA_W-1:0] memwb_rd_addr,
   input  logic [XLEN-1:0] memwb_result,
   output logic [XLEN-1:0] fwd_data
);

   logic rs_nonzero;
   logic exmem_hit;
   logic memwb_hit;

   assign rs_nonzero = (rs_addr != '0);
   assign exmem_hit  = exmem_reg_write && (exmem_rd_addr == rs_addr) && rs_nonzero;
   assign memwb_hit  = memwb_reg_write && (memwb_rd_addr == rs_addr) && rs_nonzero;

   assign fwd_data = exmem_hit ? exmem_result :
                     memwb_hit ? memwb_result :
                                 rs_data;

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register plus the execute-stage operand front end.
// Captures decoded fields from ID, forwards EX/MEM and MEM/WB results onto the
// registered sources, selects ALU operands, and detects load-use hazards.
// Edge priority: rst > flush > stall > load_use_hazard > normal capture.
// The registered record is sized by pipe_pkg widths; the parameters must stay
// at those values.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   stall, flush                  downstream hold, branch/trap kill
//   id_*                          decoded instruction from ID
//   exmem_*, memwb_*              forwarding producers
//   load_use_hazard               freeze request to PC and IF/ID
//   ex_valid, ex_pc, ex_alu_op    registered instruction state
//   operand1, operand2            ALU operands (forwarded and selected)
//   ex_store_data                 forwarded rs2 for stores
//   ex_rd_addr, ex_reg_write,
//   ex_mem_read, ex_mem_write     registered destination and control
// -----------------------------------------------------------------------------
module id_ex_stage
   import pipe_pkg::*;
#(
   parameter int XLEN = PIPE_XLEN,
   parameter int RA_W = PIPE_RA_W,
   parameter int OP_W = PIPE_OP_W
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            flush,
   input  logic            id_valid,
   input  logic [XLEN-1:0] id_pc,
   input  logic [RA_W-1:0] id_rs1_addr,
   input  logic [RA_W-1:0] id_rs2_addr,
   input  logic [RA_W-1:0] id_rd_addr,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic            id_uses_rs1,
   input  logic            id_uses_rs2,
   input  logic [XLEN-1:0] id_imm,
   input  logic [OP_W-1:0] id_alu_op,
   input  logic [1:0]      id_op1_sel,
   input  logic [1:0]      id_op2_sel,
   input  logic            id_reg_write,
   input  logic            id_mem_read,
   input  logic            id_mem_write,
   input  logic            exmem_reg_write,
   input  logic [RA_W-1:0] exmem_rd_addr,
   input  logic [XLEN-1:0] exmem_result,
   input  logic            memwb_reg_write,
   input  logic [RA_W-1:0] memwb_rd_addr,
   input  logic [XLEN-1:0] memwb_result,
   output logic            load_use_hazard,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_pc,
   output logic [OP_W-1:0] ex_alu_op,
   output logic [XLEN-1:0] operand1,
   output logic [XLEN-1:0] operand2,
   output logic [XLEN-1:0] ex_store_data,
   output logic [RA_W-1:0] ex_rd_addr,
   output logic            ex_reg_write,
   output logic            ex_mem_read,
   output logic            ex_mem_write
);

   id_ex_t          ex_q;
   id_ex_t          id_d;
   logic [XLEN-1:0] rs1_fwd;
   logic [XLEN-1:0] rs2_fwd;

   // ---------------------------------------------------------------------------
   // Forwarding on the registered sources
   // ---------------------------------------------------------------------------
   fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
      .rs_addr         (ex_q.rs1_addr),
      .rs_data         (ex_q.rs1_data),
      .exmem_reg_write (exmem_reg_write),
      .exmem_rd_addr   (exmem_rd_addr),
      .exmem_result    (exmem_result),
      .memwb_reg_write (memwb_reg_write),
      .memwb_rd_addr   (memwb_rd_addr),
      .memwb_result    (memwb_result),
      .fwd_data        (rs1_fwd)
   );

   fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
      .rs_addr         (ex_q.rs2_addr),
      .rs_data         (ex_q.rs2_data),
      .exmem_reg_write (exmem_reg_write),
      .exmem_rd_addr   (exmem_rd_addr),
      .exmem_result    (exmem_result),
      .memwb_reg_write (memwb_reg_write),
      .memwb_rd_addr   (memwb_rd_addr),
      .memwb_result    (memwb_result),
      .fwd_data        (rs2_fwd)
   );

   // ---------------------------------------------------------------------------
   // Load-use hazard: a load in EX whose destination is read by the valid ID
   // instruction. One bubble is enough because the load result reaches
   // MEM/WB forwarding by the time the consumer is re-captured.
   // ---------------------------------------------------------------------------
   assign load_use_hazard = ex_q.valid && ex_q.mem_read && (ex_q.rd_addr != '0) &&
                            id_valid &&
                            ((id_uses_rs1 && (id_rs1_addr == ex_q.rd_addr)) ||
                             (id_uses_rs2 && (id_rs2_addr == ex_q.rd_addr)));

   // ---------------------------------------------------------------------------
   // Next-record assembly from ID
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every field gets a default before any assignment, so no latch
      // can be inferred however this block grows.
      id_d           = '0;
      id_d.valid     = id_valid;
      id_d.pc        = id_pc;
      id_d.rs1_addr  = id_rs1_addr;
      id_d.rs2_addr  = id_rs2_addr;
      id_d.rd_addr   = id_rd_addr;
      id_d.rs1_data  = id_rs1_data;
      id_d.rs2_data  = id_rs2_data;
      id_d.imm       = id_imm;
      id_d.alu_op    = id_alu_op;
      id_d.op1_sel   = id_op1_sel;
      id_d.op2_sel   = id_op2_sel;
      id_d.reg_write = id_reg_write;
      id_d.mem_read  = id_mem_read;
      id_d.mem_write = id_mem_write;
   end

   // ---------------------------------------------------------------------------
   // ID/EX register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q <= '0;
      end else if (flush) begin
         ex_q <= '0;
      end else if (stall) begin
         // Hold the instruction but refresh its source data with the
         // forwarded values, so a producer retiring during the hold is kept.
         ex_q.rs1_data <= rs1_fwd;
         ex_q.rs2_data <= rs2_fwd;
      end else if (load_use_hazard) begin
         ex_q <= '0;
      end else begin
         ex_q <= id_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Operand select
   // ---------------------------------------------------------------------------
   always_comb begin
      operand1 = '0;
      case (ex_q.op1_sel)
         OP1_RS1: operand1 = rs1_fwd;
         OP1_PC:  operand1 = ex_q.pc;
         default: operand1 = '0;
      endcase
   end

   always_comb begin
      operand2 = '0;
      case (ex_q.op2_sel)
         OP2_RS2:  operand2 = rs2_fwd;
         OP2_IMM:  operand2 = ex_q.imm;
         OP2_FOUR: operand2 = XLEN'(32'd4);
         default:  operand2 = '0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registered outputs; control is gated so an invalid slot has no effect
   // ---------------------------------------------------------------------------
   assign ex_valid      = ex_q.valid;
   assign ex_pc         = ex_q.pc;
   assign ex_alu_op     = ex_q.alu_op;
   assign ex_rd_addr    = ex_q.rd_addr;
   assign ex_store_data = rs2_fwd;
   assign ex_reg_write  = ex_q.valid & ex_q.reg_write;
   assign ex_mem_read   = ex_q.valid & ex_q.mem_read;
   assign ex_mem_write  = ex_q.valid & ex_q.mem_write;

endmodule
